// File: rtl/cpu_types_pkg.sv
// ---------------------------------------------------------------------------
// cpu_types_pkg
// Shared types for the pipelined MIPS datapath.
//   sb_entry_t : one scoreboard entry (valid / destination register / load)
//   fwd_sel_t  : forwarding-mux select, 0 = register file, k = stage k
//   reg_idx_t  : architectural register index
// Default scoreboard geometry lives here so the top, its interface and the
// per-port matcher all agree on widths.
// ---------------------------------------------------------------------------
package cpu_types_pkg;

    localparam int SB_STAGES     = 3;
    localparam int SB_READ_PORTS = 2;
    localparam int SB_LOAD_STAGE = 2;
    localparam int SB_CNT_W      = 16;
    localparam int FWD_SEL_W     = $clog2(SB_STAGES + 1);

    typedef logic [4:0] reg_idx_t;

    typedef struct packed {
        logic     valid;
        reg_idx_t wsel;
        logic     is_load;
    } sb_entry_t;

    typedef logic [FWD_SEL_W-1:0] fwd_sel_t;

endpackage

// File: rtl/fwd_scoreboard_if.sv
// ---------------------------------------------------------------------------
// fwd_scoreboard_if
// Decode-side bundle between the pipeline control and the forwarding
// scoreboard.
//   master : pipeline side, drives decode/exec info, receives controls
//   slave  : scoreboard side
// Signals:
//   advance, id_valid, id_ren, id_rsel, id_wen, id_wsel, id_is_load,
//   ex_branch_taken                        -> scoreboard
//   fwd_sel, stall, flush_fd, flush_de, stall_count <- scoreboard
// ---------------------------------------------------------------------------
interface fwd_scoreboard_if #(
    parameter int READ_PORTS = 2,
    parameter int STAGES     = 3,
    parameter int CNT_W      = 16
);
    localparam int SEL_W = $clog2(STAGES + 1);

    logic                             advance;
    logic                             id_valid;
    logic [READ_PORTS-1:0]            id_ren;
    logic [READ_PORTS-1:0][4:0]       id_rsel;
    logic                             id_wen;
    logic [4:0]                       id_wsel;
    logic                             id_is_load;
    logic                             ex_branch_taken;
    logic [READ_PORTS-1:0][SEL_W-1:0] fwd_sel;
    logic                             stall;
    logic                             flush_fd;
    logic                             flush_de;
    logic [CNT_W-1:0]                 stall_count;

    modport master (
        output advance, id_valid, id_ren, id_rsel, id_wen, id_wsel,
               id_is_load, ex_branch_taken,
        input  fwd_sel, stall, flush_fd, flush_de, stall_count
    );

    modport slave (
        input  advance, id_valid, id_ren, id_rsel, id_wen, id_wsel,
               id_is_load, ex_branch_taken,
        output fwd_sel, stall, flush_fd, flush_de, stall_count
    );

endinterface

// File: rtl/fwd_port_match.sv
// ---------------------------------------------------------------------------
// fwd_port_match
// Priority search for one decode read port over the scoreboard entries.
// Ports:
//   entries   in  scoreboard, index 0 = stage 1 (youngest)
//   ren       in  port read enable
//   rsel      in  port source register
//   sel       out forwarding select (0 = register file, k = stage k)
//   stall_req out load-use hazard on this port
// ---------------------------------------------------------------------------
module fwd_port_match
    import cpu_types_pkg::*;
#(
    parameter int STAGES     = SB_STAGES,
    parameter int LOAD_STAGE = SB_LOAD_STAGE,
    parameter int SEL_W      = $clog2(STAGES + 1)
) (
    input  sb_entry_t [STAGES-1:0] entries,
    input  logic                   ren,
    input  reg_idx_t               rsel,
    output logic [SEL_W-1:0]       sel,
    output logic                   stall_req
);

    logic found;

    // Youngest producer wins: scan from stage 1 outward and stop at the
    // first match. A load that has not reached LOAD_STAGE has no data yet,
    // so the port asks for a stall and reads the register file meanwhile.
    // Register 0 is hardwired zero and never matches.
    always_comb begin
        sel       = '0;
        stall_req = 1'b0;
        found     = 1'b0;
        if (ren && rsel != '0) begin
            for (int k = 0; k < STAGES; k++) begin
                if (!found && entries[k].valid && entries[k].wsel == rsel) begin
                    found = 1'b1;
                    if (entries[k].is_load && (k + 1) < LOAD_STAGE) begin
                        stall_req = 1'b1;
                    end else begin
                        sel = SEL_W'(k + 1);
                    end
                end
            end
        end
    end

endmodule

// File: rtl/fwd_scoreboard.sv
// ---------------------------------------------------------------------------
// fwd_scoreboard
// Forwarding and hazard scoreboard beside the decode stage. Tracks every
// in-flight register write in a shift register (one entry per stage after
// decode) and derives forwarding selects, load-use stalls, branch flushes
// and a saturating stall-cycle counter.
// Ports:
//   CLK  in  clock
//   RST  in  synchronous active-high reset
//   bus  slave modport of fwd_scoreboard_if (decode info in, controls out)
// ---------------------------------------------------------------------------
module fwd_scoreboard
    import cpu_types_pkg::*;
#(
    parameter int STAGES     = SB_STAGES,
    parameter int READ_PORTS = SB_READ_PORTS,
    parameter int LOAD_STAGE = SB_LOAD_STAGE,
    parameter int CNT_W      = SB_CNT_W
) (
    input  logic           CLK,
    input  logic           RST,
    fwd_scoreboard_if.slave bus
);

    localparam int SEL_W = $clog2(STAGES + 1);

    sb_entry_t [STAGES-1:0]           sb;
    sb_entry_t                        ins;
    logic [READ_PORTS-1:0]            port_req;
    logic [READ_PORTS-1:0][SEL_W-1:0] port_sel;
    logic                             stall_c;
    logic [CNT_W-1:0]                 count;

    genvar p;
    generate
        for (p = 0; p < READ_PORTS; p++) begin : g_port
            fwd_port_match #(
                .STAGES     (STAGES),
                .LOAD_STAGE (LOAD_STAGE),
                .SEL_W      (SEL_W)
            ) u_match (
                .entries   (sb),
                .ren       (bus.id_ren[p]),
                .rsel      (bus.id_rsel[p]),
                .sel       (port_sel[p]),
                .stall_req (port_req[p])
            );
        end
    endgenerate

    // A taken branch discards the decode instruction, so any hazard it
    // would have caused is moot and the flush takes priority over stall.
    // Stalled or flushed decode instructions leave a bubble behind.
    always_comb begin
        stall_c     = bus.id_valid & (|port_req) & ~bus.ex_branch_taken;
        ins.valid   = bus.id_valid & bus.id_wen & (bus.id_wsel != 5'd0)
                      & ~stall_c & ~bus.ex_branch_taken;
        ins.wsel    = bus.id_wsel;
        ins.is_load = bus.id_is_load;
    end

    assign bus.fwd_sel     = port_sel;
    assign bus.stall       = stall_c;
    assign bus.flush_fd    = bus.ex_branch_taken;
    assign bus.flush_de    = bus.ex_branch_taken;
    assign bus.stall_count = count;

    // The whole scoreboard moves one stage per advancing cycle; the oldest
    // entry falls off the end (register file write has happened).
    always_ff @(posedge CLK) begin
        if (RST) begin
            sb <= '0;
        end else if (bus.advance) begin
            for (int k = STAGES - 1; k > 0; k--) begin
                sb[k] <= sb[k-1];
            end
            sb[0] <= ins;
        end
    end

    // Only stalls that actually cost a pipeline cycle are counted; the
    // counter pins at all-ones instead of wrapping.
    always_ff @(posedge CLK) begin
        if (RST) begin
            count <= '0;
        end else if (bus.advance && stall_c && count != '1) begin
            count <= count + 1'b1;
        end
    end

endmodule
